// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the restoring divider: width constants, the
// sequencer state encoding and the control-strobe bundle.
package div_sequencer_pkg;

  localparam int DIV_N     = 10;
  localparam int DIV_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    ITER = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  // Every strobe the sequencer drives toward the datapath, plus status.
  typedef struct packed {
    logic acc_init;
    logic acc_ld;
    logic q_init;
    logic q_shift;
    logic q_bit;
    logic b_ld;
    logic busy;
    logic done;
    logic dz_err;
  } ctrl_t;

endpackage

// File: rtl/div_sequencer_if.sv
// Handshake and datapath-control bundle between the divider sequencer and
// the accumulator / quotient / divisor registers.
interface div_sequencer_if
  import div_sequencer_pkg::*;
#(
  parameter int CNT_W = DIV_CNT_W
);

  logic             start;
  logic             divisor_zero;
  logic             sub_neg;
  logic             acc_init;
  logic             acc_ld;
  logic             q_init;
  logic             q_shift;
  logic             q_bit;
  logic             b_ld;
  logic             busy;
  logic             done;
  logic             dz_err;
  logic [CNT_W-1:0] iter;

  // Requester / datapath side.
  modport master (
    output start, divisor_zero, sub_neg,
    input  acc_init, acc_ld, q_init, q_shift, q_bit, b_ld,
    input  busy, done, dz_err, iter
  );

  // Sequencer side.
  modport slave (
    input  start, divisor_zero, sub_neg,
    output acc_init, acc_ld, q_init, q_shift, q_bit, b_ld,
    output busy, done, dz_err, iter
  );

endinterface

// File: rtl/div_iter_counter.sv
// Iteration counter: cleared on demand, counts 0..N-1 while enabled and
// wraps back to 0 after the final iteration.
module div_iter_counter
  import div_sequencer_pkg::*;
#(
  parameter int N     = DIV_N,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic wrap;

  assign last = (count == CNT_W'(N - 1));
  // Wrapping on >= rather than == keeps the count inside 0..N-1 even if it
  // were ever disturbed to an out-of-range value.
  assign wrap = (count >= CNT_W'(N - 1));

  // Count register with synchronous reset and clear.
  // NOTE: clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Control FSM for the N-bit restoring shift-subtract divider: one INIT
// cycle, N ITER cycles, one DONE cycle; divide-by-zero short-cuts to ERR.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int N     = DIV_N,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic            clock,
  input  logic            rst,
  div_sequencer_if.slave  bus
);

  state_t           state;
  state_t           next_state;
  ctrl_t            ctrl;
  logic             cnt_clear;
  logic             cnt_en;
  logic             cnt_last;
  logic [CNT_W-1:0] count;

  div_iter_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_counter (
    .clock  (clock),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (count),
    .last   (cnt_last)
  );

  // State register; reset wins over every input and every state.
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and state-gated strobes.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = IDLE;
    ctrl       = '0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = bus.divisor_zero ? ERR : INIT;
        end else begin
          next_state = IDLE;
        end
      end
      INIT: begin
        ctrl.acc_init = 1'b1;
        ctrl.q_init   = 1'b1;
        ctrl.b_ld     = 1'b1;
        ctrl.busy     = 1'b1;
        cnt_clear     = 1'b1;
        next_state    = ITER;
      end
      ITER: begin
        // A non-negative trial difference means the divisor fits: keep the
        // subtraction and shift in a 1.
        ctrl.q_shift = 1'b1;
        ctrl.busy    = 1'b1;
        ctrl.acc_ld  = ~bus.sub_neg;
        ctrl.q_bit   = ~bus.sub_neg;
        cnt_en       = 1'b1;
        next_state   = cnt_last ? DONE : ITER;
      end
      DONE: begin
        ctrl.done  = 1'b1;
        next_state = IDLE;
      end
      ERR: begin
        ctrl.done   = 1'b1;
        ctrl.dz_err = 1'b1;
        next_state  = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign bus.acc_init = ctrl.acc_init;
  assign bus.acc_ld   = ctrl.acc_ld;
  assign bus.q_init   = ctrl.q_init;
  assign bus.q_shift  = ctrl.q_shift;
  assign bus.q_bit    = ctrl.q_bit;
  assign bus.b_ld     = ctrl.b_ld;
  assign bus.busy     = ctrl.busy;
  assign bus.done     = ctrl.done;
  assign bus.dz_err   = ctrl.dz_err;
  assign bus.iter     = count;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic clock;
  logic rst;

  div_sequencer_if #(.CNT_W(DIV_CNT_W)) bus ();

  div_sequencer #(
    .N     (DIV_N),
    .CNT_W (DIV_CNT_W)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Output vector order: acc_init acc_ld q_init q_shift q_bit b_ld busy done dz_err
  localparam logic [8:0] O_IDLE = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_INIT = 9'b1_0_1_0_0_1_1_0_0;
  localparam logic [8:0] O_DONE = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] O_ERR  = 9'b0_0_0_0_0_0_0_1_1;

  function automatic logic [8:0] outs();
    return {bus.acc_init, bus.acc_ld, bus.q_init, bus.q_shift, bus.q_bit,
            bus.b_ld, bus.busy, bus.done, bus.dz_err};
  endfunction

  function automatic logic [8:0] o_iter(input logic fit);
    return {1'b0, fit, 1'b0, 1'b1, fit, 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [8:0] exp_o, input int exp_iter);
    check({tag, ".outs"}, 16'(outs()), 16'(exp_o));
    check({tag, ".iter"}, 16'(bus.iter), 16'(exp_iter));
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic pat   [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic fit_e [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  int done_cnt;
  int done_at;
  int done_at2;

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.divisor_zero = 1'b0;
    bus.sub_neg      = 1'b0;

    // Reset for two cycles.
    tick();
    tick();
    check_outs("reset", O_IDLE, 0);
    rst = 1'b0;
    tick();
    check_outs("idle", O_IDLE, 0);

    // Basic run with iteration decode pattern; sub_neg held 0 outside ITER
    // so any leak of acc_ld/q_bit would show up as 1.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_outs("c1_init", O_INIT, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.sub_neg = pat[i];
      #1;
      check_outs($sformatf("iter%0d", i), o_iter(fit_e[i]), i);
    end
    bus.sub_neg = 1'b0;
    tick();
    check_outs("c12_done", O_DONE, 0);
    tick();
    check_outs("c13_idle", O_IDLE, 0);

    // Divide by zero.
    bus.start        = 1'b1;
    bus.divisor_zero = 1'b1;
    tick();
    bus.start        = 1'b0;
    bus.divisor_zero = 1'b0;
    check_outs("dz_c1", O_ERR, 0);
    tick();
    check_outs("dz_c2", O_IDLE, 0);
    tick();
    check_outs("dz_c3", O_IDLE, 0);

    // Start re-pulsed while busy (cycle 5) must be ignored.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    done_cnt  = 0;
    done_at   = -1;
    for (int c = 2; c <= 20; c++) begin
      bus.start = (c == 6);   // high during cycle 5, sampled at its end
      tick();
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
    end
    bus.start = 1'b0;
    check("busy_ign.done_cycle", 16'(done_at), 16'd12);
    check("busy_ign.done_count", 16'(done_cnt), 16'd1);
    check_outs("busy_ign.idle", O_IDLE, 0);

    // Reset mid-ITER at iter=5 (cycle 7).
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 2; c <= 7; c++) tick();
    check("midrst.iter_before", 16'(bus.iter), 16'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outs("midrst.after", O_IDLE, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      if (bus.done && done_at < 0) done_at = c;
      if (done_at < 0) tick();
    end
    check("midrst.restart_done", 16'(done_at), 16'd12);
    tick();
    check_outs("midrst.idle", O_IDLE, 0);

    // Start held high for 30 cycles: done in cycles 12 and 25.
    bus.start = 1'b1;
    done_cnt  = 0;
    done_at   = -1;
    done_at2  = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
        else if (done_at2 < 0) done_at2 = c;
      end
    end
    bus.start = 1'b0;
    check("held.done_count", 16'(done_cnt), 16'd2);
    check("held.first_done", 16'(done_at), 16'd12);
    check("held.second_done", 16'(done_at2), 16'd25);
    for (int c = 0; c < 15; c++) tick();
    check_outs("held.drained", O_IDLE, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Control unit for the 10-bit restoring shift-subtract divider.
- Sits directly upstream of the accumulator register and the quotient register. It drives their init and load strobes and consumes the subtractor sign bit.
- Runs one start/done transaction: one init cycle, N iteration cycles, one completion cycle.
- Divide-by-zero is detected before any iteration runs.

Parameters:
- N, 10, dividend/divisor width; also the number of iterations.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > N.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a division; sampled only in IDLE.
- divisor_zero  in  1  divisor operand == 0; sampled with start.
- sub_neg  in  1  sign bit of the accumulator-minus-divisor result (bit N of the N+1-bit result).
- acc_init  out  1  accumulator init strobe, wired to the accumulator's rst pin.
- acc_ld  out  1  accumulator keeps the subtraction result (1) or the shifted value (0).
- q_init  out  1  load dividend into the quotient register.
- q_shift  out  1  shift quotient register left one bit.
- q_bit  out  1  new quotient LSB shifted in.
- b_ld  out  1  capture divisor into the divisor register.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- dz_err  out  1  one-cycle divide-by-zero pulse, coincident with done.
- iter  out  CNT_W  current iteration index, 0..N-1.

Behaviour:
- States: IDLE, INIT, ITER, DONE, ERR. State is encoded in a registered state variable; the counter is registered.
- Reset: state=IDLE, iter=0. All outputs 0 in the cycle after rst is sampled. Reset has priority over every other input and over every state.
- IDLE transitions:
  - start=1 and divisor_zero=0 -> INIT.
  - start=1 and divisor_zero=1 -> ERR.
  - Otherwise stay in IDLE.
- INIT (1 cycle): acc_init=q_init=b_ld=1, busy=1, counter cleared to 0 -> ITER.
- ITER (exactly N cycles):
  - q_shift=1, busy=1.
  - acc_ld = ~sub_neg and q_bit = ~sub_neg. Both are combinational from sub_neg and gated by state==ITER.
  - Counter increments each cycle. When iter==N-1 -> DONE, counter returns to 0.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- ERR (1 cycle): done=1, dz_err=1; no strobes to the datapath -> IDLE.
- Output gating: outside the listed states every strobe is 0. acc_ld, q_bit and q_shift are never asserted outside ITER.
- Latency (start sampled at edge 0):
  - INIT occupies cycle 1; ITER occupies cycles 2..N+1; done is high in cycle N+2 (cycle 12 for N=10).
  - The error path asserts done/dz_err in cycle 1.
- start outside IDLE is ignored; no queuing.
- A start held high through DONE is accepted on the following IDLE cycle, giving minimum back-to-back spacing of N+3 cycles.
- divisor_zero is ignored outside IDLE.
- Reset mid-ITER: the next cycle is IDLE with all outputs 0. Datapath register contents are don't-care until the next INIT.
- Counter never exceeds N-1. Reaching an illegal state encoding forces IDLE on the next edge.

Decomposition:
- Shared package holds:
  - state enum (IDLE, INIT, ITER, DONE, ERR);
  - constants DIV_N=10 and DIV_CNT_W=4, shared with the accumulator/quotient/divisor registers.
- One natural sub-module: div_iter_counter. It takes clear/enable inputs and outputs count and last (count==N-1). The FSM proper stays in div_sequencer.

Test Plan:
- Basic run: rst 2 cycles, start pulse with divisor_zero=0.
  - Required: acc_init/q_init/b_ld high in cycle 1; q_shift high in cycles 2..11; done single pulse in cycle 12; busy high in cycles 1..11.
- Iteration decode: drive sub_neg = 1,0,1,1,0,0,1,0,1,0 across the 10 ITER cycles.
  - Required: acc_ld and q_bit = 0,1,0,0,1,1,0,1,0,1; iter steps 0..9.
- Divide by zero: start=1, divisor_zero=1.
  - Required: done=dz_err=1 in cycle 1 only; no INIT/ITER strobes; back in IDLE in cycle 2.
- Busy ignore: re-pulse start in cycle 5.
  - Required: no restart, done still in cycle 12, exactly one done pulse.
- Mid-op reset: assert rst during ITER with iter=5.
  - Required: next cycle all outputs 0 and iter=0. A fresh start then completes with done 12 cycles after it is sampled.
- Continuous start held high for 30 cycles.
  - Required: done pulses in cycles 12 and 25 (spacing N+3=13).
